shift_rows_stage: RTL and testbench

// - Registered ShiftRows / InvShiftRows stage with a valid/ready handshake.
// - Sits directly downstream of the byte-substitution stage and consumes its 4x32 state.
// - Feeds the MixColumns / AddRoundKey path of the cipher unit.
// - Provides a 2-entry elastic buffer (main + skid register), so upstream sees a

---
 rtl/shift_rows_stage_if.sv | 39 +++
 rtl/shift_rows_stage.sv | 116 +++++++++++
 tb/tb_shift_rows_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_rows_stage_if.sv
// Handshake bundle for the ShiftRows stage: input beat side and output beat side.
// The stage takes the slave view; the driving environment takes the master view.
interface shift_rows_stage_if #(
    parameter int TAG_W = 4
);
    logic [3:0][31:0] state_i;
    logic             enc_dec;
    logic [TAG_W-1:0] tag_i;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][31:0] state_o;
    logic [TAG_W-1:0] tag_o;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  state_i,
        input  enc_dec,
        input  tag_i,
        input  in_valid,
        output in_ready,
        output state_o,
        output tag_o,
        output out_valid,
        input  out_ready
    );

    modport master (
        output state_i,
        output enc_dec,
        output tag_i,
        output in_valid,
        input  in_ready,
        input  state_o,
        input  tag_o,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/shift_rows_stage.sv
// Registered ShiftRows / InvShiftRows stage with a 2-entry elastic buffer.
// M drives the outputs; S catches the beat accepted while M is stalled.
module shift_rows_stage #(
    parameter int TAG_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    shift_rows_stage_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_e;

    typedef logic [3:0][31:0] state_t;

    // Row r rotates by r columns: left for encrypt, right for decrypt.
    function automatic state_t shift_rows(input state_t s, input logic enc);
        state_t res;
        logic [1:0] src;
        res = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                src = enc ? 2'(col + row) : 2'(col - row);
                res[col][8*row +: 8] = s[src][8*row +: 8];
            end
        end
        return res;
    endfunction

    fill_e            fill_q, fill_d;
    state_t           m_state_q, m_state_d;
    state_t           s_state_q, s_state_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d;
    logic [TAG_W-1:0] s_tag_q, s_tag_d;
    logic             in_ready_q, in_ready_d;

    state_t           beat_state;
    logic             in_xfer;
    logic             out_xfer;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (fill_q != EMPTY);
    assign bus.state_o   = m_state_q;
    assign bus.tag_o     = m_tag_q;

    // Fill-level transitions and M/S loading; shift is applied before capture.
    always_comb begin
        fill_d     = fill_q;
        m_state_d  = m_state_q;
        m_tag_d    = m_tag_q;
        s_state_d  = s_state_q;
        s_tag_d    = s_tag_q;
        beat_state = shift_rows(bus.state_i, bus.enc_dec);
        in_xfer    = bus.in_valid && in_ready_q;
        out_xfer   = (fill_q != EMPTY) && bus.out_ready;

        unique case (fill_q)
            EMPTY: begin
                if (in_xfer) begin
                    fill_d    = ONE;
                    m_state_d = beat_state;
                    m_tag_d   = bus.tag_i;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    m_state_d = beat_state;
                    m_tag_d   = bus.tag_i;
                end else if (in_xfer) begin
                    fill_d    = FULL;
                    s_state_d = beat_state;
                    s_tag_d   = bus.tag_i;
                end else if (out_xfer) begin
                    fill_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    fill_d    = ONE;
                    m_state_d = s_state_q;
                    m_tag_d   = s_tag_q;
                    s_state_d = '0;
                    s_tag_d   = '0;
                end
            end
            default: begin
                fill_d = EMPTY;
            end
        endcase

        in_ready_d = (fill_d != FULL);
    end

    // State and data registers; reset discards every held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= EMPTY;
            m_state_q  <= '0;
            m_tag_q    <= '0;
            s_state_q  <= '0;
            s_tag_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            m_state_q  <= m_state_d;
            m_tag_q    <= m_tag_d;
            s_state_q  <= s_state_d;
            s_tag_q    <= s_tag_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_shift_rows_stage.sv
// Directed bench for shift_rows_stage: vector table plus handshake sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_shift_rows_stage;

    logic clk;
    logic rst_n;

    shift_rows_stage_if #(.TAG_W(4)) bus ();

    shift_rows_stage #(.TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [127:0] st;
        logic         enc;
        logic [3:0]   tag;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];

    logic [127:0] stream_in  [16];
    logic [127:0] stream_exp [16];

    // Reference: byte (row r, col c) lives at bit 32*c + 8*r.
    function automatic logic [127:0] ref_shift(input logic [127:0] s, input logic enc);
        logic [127:0] res;
        int src;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = enc ? (c + r) % 4 : (c + 4 - r) % 4;
                res[32*c + 8*r +: 8] = s[32*src + 8*r +: 8];
            end
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] st, input logic enc, input logic [3:0] tag);
        bus.in_valid = v;
        bus.state_i  = st;
        bus.enc_dec  = enc;
        bus.tag_i    = tag;
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
    localparam logic [127:0] FIPS_OUT = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{FIPS_IN, 1'b1, 4'd1, FIPS_OUT};
        vecs[1] = '{FIPS_OUT, 1'b0, 4'd2, FIPS_IN};
        vecs[2] = '{128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b1, 4'd3,
                    128'h0b06010c_07020d08_030e0904_0f0a0500};
        vecs[3] = '{128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, 4'd4,
                    128'h0306090c_0f020508_0b0e0104_070a0d00};
        vecs[4] = '{128'haabbccdd_aabbccdd_aabbccdd_aabbccdd, 1'b1, 4'hf,
                    128'haabbccdd_aabbccdd_aabbccdd_aabbccdd};

        for (int i = 0; i < 16; i++) begin
            stream_in[i]  = {$urandom, $urandom, $urandom, $urandom};
            stream_exp[i] = ref_shift(stream_in[i], i[0] == 1'b0);
        end

        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, 1'b0, 4'd0);
        #12;
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_state_o", bus.state_o, '0);
        check("rst_tag_o", 128'(bus.tag_o), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", 128'(bus.in_ready), 128'd1);

        // Table vectors, one per cycle, drained immediately.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vecs[i].st, vecs[i].enc, vecs[i].tag);
            tick();
            check($sformatf("vec%0d_valid", i), 128'(bus.out_valid), 128'd1);
            check($sformatf("vec%0d_state", i), bus.state_o, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), 128'(bus.tag_o), 128'(vecs[i].tag));
        end
        drive(1'b0, '0, 1'b0, 4'd0);
        tick();
        check("drain_valid", 128'(bus.out_valid), 128'd0);

        // Streaming: 16 back-to-back beats, alternating mode.
        for (int i = 0; i < 16; i++) begin
            check($sformatf("stream%0d_in_ready", i), 128'(bus.in_ready), 128'd1);
            drive(1'b1, stream_in[i], i[0] == 1'b0, 4'(i));
            tick();
            check($sformatf("stream%0d_valid", i), 128'(bus.out_valid), 128'd1);
            check($sformatf("stream%0d_state", i), bus.state_o, stream_exp[i]);
            check($sformatf("stream%0d_tag", i), 128'(bus.tag_o), 128'(i));
        end
        drive(1'b0, '0, 1'b0, 4'd0);
        tick();
        check("stream_drain", 128'(bus.out_valid), 128'd0);

        // Backpressure: three beats offered with out_ready low.
        bus.out_ready = 1'b0;
        drive(1'b1, stream_in[0], 1'b1, 4'd10);
        tick();
        check("bp_ready_b1", 128'(bus.in_ready), 128'd1);
        drive(1'b1, stream_in[1], 1'b0, 4'd11);
        tick();
        check("bp_full_ready", 128'(bus.in_ready), 128'd0);
        drive(1'b1, stream_in[2], 1'b1, 4'd12);
        tick();
        tick();
        check("bp_hold_ready", 128'(bus.in_ready), 128'd0);
        check("bp_hold_state", bus.state_o, ref_shift(stream_in[0], 1'b1));
        check("bp_hold_tag", 128'(bus.tag_o), 128'd10);
        bus.out_ready = 1'b1;
        tick();
        check("bp_out1_state", bus.state_o, ref_shift(stream_in[1], 1'b0));
        check("bp_out1_tag", 128'(bus.tag_o), 128'd11);
        check("bp_out1_ready", 128'(bus.in_ready), 128'd1);
        tick();
        check("bp_out2_state", bus.state_o, ref_shift(stream_in[2], 1'b1));
        check("bp_out2_tag", 128'(bus.tag_o), 128'd12);
        drive(1'b0, '0, 1'b0, 4'd0);
        tick();
        check("bp_drain", 128'(bus.out_valid), 128'd0);

        // Simultaneous in/out transfer while holding one beat.
        bus.out_ready = 1'b0;
        drive(1'b1, stream_in[3], 1'b1, 4'd5);
        tick();
        drive(1'b0, '0, 1'b0, 4'd0);
        tick();
        check("sim_one_valid", 128'(bus.out_valid), 128'd1);
        bus.out_ready = 1'b1;
        drive(1'b1, stream_in[4], 1'b0, 4'd6);
        tick();
        check("sim_valid", 128'(bus.out_valid), 128'd1);
        check("sim_state", bus.state_o, ref_shift(stream_in[4], 1'b0));
        check("sim_tag", 128'(bus.tag_o), 128'd6);
        check("sim_ready", 128'(bus.in_ready), 128'd1);
        drive(1'b0, '0, 1'b0, 4'd0);
        tick();
        check("sim_drain", 128'(bus.out_valid), 128'd0);

        // Async reset while full.
        bus.out_ready = 1'b0;
        drive(1'b1, stream_in[5], 1'b1, 4'd7);
        tick();
        drive(1'b1, stream_in[6], 1'b1, 4'd8);
        tick();
        check("ar_full_ready", 128'(bus.in_ready), 128'd0);
        drive(1'b1, stream_in[7], 1'b0, 4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 128'(bus.out_valid), 128'd0);
        check("ar_in_ready", 128'(bus.in_ready), 128'd0);
        check("ar_state_o", bus.state_o, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("ar_rel_ready", 128'(bus.in_ready), 128'd0);
        tick();
        check("ar_edge1_ready", 128'(bus.in_ready), 128'd1);
        check("ar_edge1_valid", 128'(bus.out_valid), 128'd0);
        tick();
        check("ar_first_valid", 128'(bus.out_valid), 128'd1);
        check("ar_first_state", bus.state_o, ref_shift(stream_in[7], 1'b0));
        check("ar_first_tag", 128'(bus.tag_o), 128'd9);
        drive(1'b0, '0, 1'b0, 4'd0);
        tick();
        check("ar_drain", 128'(bus.out_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
